// File: rtl/acc_regfile_wb.sv
// Writeback stage after the ALU: accumulator, small register file, zero/neg flags
// and a retired-operation counter, all committed on a valid/ready handshake.
module acc_regfile_wb #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REG_BIT_CNT = 2,
    parameter int unsigned CNTR_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   wb_valid,
    output logic                   wb_ready,
    input  logic [1:0]             wb_sel,
    input  logic [REG_BIT_CNT-1:0] wb_reg_addr,
    input  logic                   hold,
    input  logic [REG_BIT_CNT-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  acc_out,
    output logic                   zero_flag,
    output logic                   neg_flag,
    output logic [CNTR_WIDTH-1:0]  retire_cnt
);

    localparam int unsigned REG_DEPTH = 2 ** REG_BIT_CNT;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_ACC   = 2'b01,
        SEL_REG   = 2'b10,
        SEL_STORE = 2'b11
    } wb_sel_e;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  zero_q, zero_d;
    logic                  neg_q, neg_d;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [REG_DEPTH];
    logic                  accept_c;

    assign wb_ready = !rst && !hold;
    assign accept_c = wb_valid && wb_ready;

    // Reads come from stored state only; bypassing the in-flight write would
    // close a combinational loop through the ALU.
    assign rd_data    = regs_q[rd_addr];
    assign acc_out    = acc_q;
    assign zero_flag  = zero_q;
    assign neg_flag   = neg_q;
    assign retire_cnt = cnt_q;

    always_comb begin
        acc_d  = acc_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        regs_d = regs_q;
        if (accept_c) begin
            cnt_d = cnt_q + CNTR_WIDTH'(1);
            case (wb_sel_e'(wb_sel))
                SEL_ACC: begin
                    acc_d  = alu_result;
                    zero_d = (alu_result == '0);
                    neg_d  = alu_result[DATA_WIDTH-1];
                end
                SEL_REG:   regs_d[wb_reg_addr] = alu_result;
                SEL_STORE: regs_d[wb_reg_addr] = acc_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            zero_q <= 1'b1;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            acc_q  <= acc_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            regs_q <= regs_d;
        end
    end

endmodule
